// File: rtl/buffer_64_to_512_arbiter.sv
// ----------------------------------------------------------------------------
// buffer_64_to_512_arbiter
//
// Shares one 64-to-512 width-converting buffer between N independent 64-bit
// message streams. A grant is held for whole 512-bit lines (8 beats), so every
// line in the buffer belongs to exactly one requester. A message tail that
// ends mid-line is zero-padded up to the line boundary. A per-line owner tag
// is emitted for the downstream line consumer.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   clr           synchronous soft clear, same effect as rst (shared with buffer)
//   req_valid     [N]      per-requester beat valid
//   req_data      [N*64]   per-requester beat, requester i at [i*64 +: 64]
//   req_last      [N]      beat is the last of its message
//   req_ready     [N]      beat accepted this cycle (combinational)
//   buf_data      [64]     beat to buffer write port (zero while padding)
//   buf_wr_en     1        buffer write strobe
//   buf_afull     1        buffer cannot take another beat
//   grant_id      [GW]     currently granted requester
//   busy          1        high in STREAM or PAD
//   line_done     1        one-cycle pulse, a 512-bit line has been completed
//   line_owner    [GW]     requester owning the completed line
//   line_last     1        completed line contains the end of a message
//   line_pad_cnt  [3]      number of zero beats padded into the completed line
//   state_dbg     [2]      FSM state (0=IDLE, 1=STREAM, 2=PAD)
//
// Handshake: a beat moves on a requester port in a cycle where both
// req_valid[i] and req_ready[i] are high at the rising clock edge; the
// buffer side has no back-pressure other than buf_afull, and buf_wr_en is
// only ever raised while buf_afull is low.
// ----------------------------------------------------------------------------
module buffer_64_to_512_arbiter #(
  parameter int N         = 4,
  parameter int MAX_LINES = 4,
  localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [N-1:0]    req_valid,
  input  logic [N*64-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic [63:0]     buf_data,
  output logic            buf_wr_en,
  input  logic            buf_afull,
  output logic [GW-1:0]   grant_id,
  output logic            busy,
  output logic            line_done,
  output logic [GW-1:0]   line_owner,
  output logic            line_last,
  output logic [2:0]      line_pad_cnt,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_PAD    = 2'd2;

  logic [1:0]    state;
  logic [2:0]    beat_cnt;
  logic [7:0]    line_cnt;
  logic [GW-1:0] rr_ptr;
  logic [2:0]    pad_cnt_q;

  logic          accept;
  logic          pad_wr;
  logic          found;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] cand;

  // --------------------------------------------------------------------------
  // Round-robin search: start one past the last owner so the previous owner
  // is considered last.
  // --------------------------------------------------------------------------
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = GW'((int'(rr_ptr) + 1 + k) % N);
      if (!found && req_valid[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and handshake (combinational on buf_afull)
  // --------------------------------------------------------------------------
  always_comb begin
    accept    = (state == S_STREAM) && req_valid[grant_id] && !buf_afull;
    pad_wr    = (state == S_PAD) && !buf_afull;
    buf_wr_en = accept || pad_wr;
    buf_data  = accept ? req_data[int'(grant_id)*64 +: 64] : 64'd0;
    req_ready = '0;
    if (state == S_STREAM && !buf_afull) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // --------------------------------------------------------------------------
  // FSM, counters and registered line report
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state        <= S_IDLE;
      beat_cnt     <= 3'd0;
      line_cnt     <= 8'd0;
      rr_ptr       <= GW'(N - 1);
      grant_id     <= '0;
      pad_cnt_q    <= 3'd0;
      line_done    <= 1'b0;
      line_owner   <= '0;
      line_last    <= 1'b0;
      line_pad_cnt <= 3'd0;
    end else begin
      line_done <= 1'b0;
      case (state)
        S_IDLE: begin
          line_cnt <= 8'd0;
          beat_cnt <= 3'd0;
          if (found) begin
            grant_id <= next_grant;
            rr_ptr   <= next_grant;
            state    <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (req_last[grant_id]) begin
              if (beat_cnt == 3'd7) begin
                line_done    <= 1'b1;
                line_owner   <= grant_id;
                line_last    <= 1'b1;
                line_pad_cnt <= 3'd0;
                line_cnt     <= 8'd0;
                state        <= S_IDLE;
              end else begin
                // Remaining beats of this line become zero padding.
                pad_cnt_q <= 3'd7 - beat_cnt;
                state     <= S_PAD;
              end
            end else if (beat_cnt == 3'd7) begin
              line_done    <= 1'b1;
              line_owner   <= grant_id;
              line_last    <= 1'b0;
              line_pad_cnt <= 3'd0;
              // Forced rotation after MAX_LINES full lines in one grant.
              if (line_cnt == 8'(MAX_LINES - 1)) begin
                line_cnt <= 8'd0;
                state    <= S_IDLE;
              end else begin
                line_cnt <= line_cnt + 8'd1;
              end
            end
          end
        end

        S_PAD: begin
          if (pad_wr) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd7) begin
              line_done    <= 1'b1;
              line_owner   <= grant_id;
              line_last    <= 1'b1;
              line_pad_cnt <= pad_cnt_q;
              line_cnt     <= 8'd0;
              state        <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_64_to_512_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for buffer_64_to_512_arbiter (N=4, MAX_LINES=2).
// Expected buffer writes and line reports are pushed into queues before the
// stimulus of each scenario; a monitor pops and compares on every buf_wr_en
// and every line_done.
// ----------------------------------------------------------------------------
module tb_buffer_64_to_512_arbiter;

  localparam int N         = 4;
  localparam int MAX_LINES = 2;
  localparam int GW        = 2;

  logic            clk;
  logic            rst;
  logic            clr;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [63:0]     buf_data;
  logic            buf_wr_en;
  logic            buf_afull;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            line_done;
  logic [GW-1:0]   line_owner;
  logic            line_last;
  logic [2:0]      line_pad_cnt;
  logic [1:0]      state_dbg;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;

  logic [63:0] exp_q[$];
  logic [5:0]  exp_line_q[$];

  buffer_64_to_512_arbiter #(.N(N), .MAX_LINES(MAX_LINES)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .buf_data(buf_data), .buf_wr_en(buf_wr_en),
    .buf_afull(buf_afull), .grant_id(grant_id), .busy(busy),
    .line_done(line_done), .line_owner(line_owner), .line_last(line_last),
    .line_pad_cnt(line_pad_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard helpers
  task automatic push_msg(input logic [63:0] base, input int nb, input int pad);
    for (int b = 0; b < nb; b++) exp_q.push_back(base + 64'(b));
    for (int p = 0; p < pad; p++) exp_q.push_back(64'd0);
  endtask

  task automatic push_line(input int owner, input int last, input int pad);
    exp_line_q.push_back({2'(owner), 1'(last), 3'(pad)});
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (buf_wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) check("unexpected_write", buf_data, 64'hdead);
        else check("write_data", buf_data, exp_q.pop_front());
      end
      if (line_done) begin
        if (exp_line_q.size() == 0) check("unexpected_line", {line_owner, line_last, line_pad_cnt}, 64'h3f);
        else check("line_report", {58'd0, line_owner, line_last, line_pad_cnt}, {58'd0, exp_line_q.pop_front()});
      end
    end
  end

  // driver: send nb beats base+b from requester id, last on final beat if with_last
  task automatic send_msg(input int id, input int nb, input logic [63:0] base, input bit with_last);
    bit acc;
    int cyc;
    for (int b = 0; b < nb; b++) begin
      req_valid[id] = 1'b1;
      req_data[id*64 +: 64] = base + 64'(b);
      req_last[id] = with_last && (b == nb - 1);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        if (req_ready[id]) acc = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: req %0d beat %0d not accepted, limit 200 cycles", id, b);
        break;
      end
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || exp_line_q.size() != 0) && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_pending", 64'(exp_q.size() + exp_line_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic afull_at_beat3();
    int cyc = 0;
    while (wr_seen < 3 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    buf_afull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("afull_no_write", 64'(buf_wr_en), 64'd0);
      check("afull_no_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    buf_afull = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; buf_afull = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_line", {line_done, line_owner, line_last, line_pad_cnt}, 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    @(posedge clk); #1;

    // 1: full line from req0, last on beat 7
    push_msg(64'h0, 8, 0);
    push_line(0, 1, 0);
    send_msg(0, 8, 64'h0, 1'b1);
    wait_drain();
    check("t1_idle", 64'(state_dbg), 64'd0);

    // 2: req2 short message, 5 beats of padding
    push_msg(64'h2000, 3, 5);
    push_line(2, 1, 5);
    send_msg(2, 3, 64'h2000, 1'b1);
    wait_drain();
    check("t2_idle", 64'(busy), 64'd0);

    // 3: req0 and req1 contend, owners alternate 0,1,0,1
    push_msg(64'h0100, 8, 0); push_line(0, 1, 0);
    push_msg(64'h1100, 8, 0); push_line(1, 1, 0);
    push_msg(64'h0200, 8, 0); push_line(0, 1, 0);
    push_msg(64'h1200, 8, 0); push_line(1, 1, 0);
    fork
      begin send_msg(0, 8, 64'h0100, 1'b1); send_msg(0, 8, 64'h0200, 1'b1); end
      begin send_msg(1, 8, 64'h1100, 1'b1); send_msg(1, 8, 64'h1200, 1'b1); end
    join
    wait_drain();

    // 4: buf_afull for 4 cycles after beat 3
    wr_seen = 0;
    push_msg(64'h3000, 8, 0);
    push_line(1, 1, 0);
    fork
      send_msg(1, 8, 64'h3000, 1'b1);
      afull_at_beat3();
    join
    wait_drain();

    // 5: forced rotation after MAX_LINES=2 lines of req1
    push_msg(64'h4000, 16, 0);
    push_line(1, 0, 0); push_line(1, 0, 0);
    push_msg(64'h5000, 8, 0); push_line(3, 1, 0);
    push_msg(64'h4010, 8, 0); push_line(1, 0, 0);
    fork
      send_msg(1, 24, 64'h4000, 1'b0);
      begin repeat (3) @(posedge clk); #1; send_msg(3, 8, 64'h5000, 1'b1); end
    join
    wait_drain();
    check("t5_still_stream", 64'(state_dbg), 64'd1);
    check("t5_grant_kept", 64'(grant_id), 64'd1);

    // 6: clr at beat 5 of a line, then requester 0 wins first
    push_msg(64'h6000, 5, 0);
    send_msg(1, 5, 64'h6000, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_state", 64'(state_dbg), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_wr_en", 64'(buf_wr_en), 64'd0);
    check("clr_ready", 64'(req_ready), 64'd0);
    check("clr_line", {line_done, line_owner, line_last, line_pad_cnt}, 64'd0);
    check("clr_grant", 64'(grant_id), 64'd0);
    @(posedge clk); #1;
    push_msg(64'h7000, 8, 0); push_line(0, 1, 0);
    push_msg(64'h8000, 8, 0); push_line(3, 1, 0);
    fork
      send_msg(0, 8, 64'h7000, 1'b1);
      send_msg(3, 8, 64'h8000, 1'b1);
    join
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_64_to_512_arbiter.md
Name: buffer_64_to_512_arbiter

Overview:
- Round-robin arbiter that shares one 64-to-512 width-converting buffer between N independent 64-bit message streams.
- Holds a grant for at least one full 512-bit line (8 beats), so every line in the buffer comes from exactly one requester.
- Zero-pads short message tails to the line boundary.
- Emits a per-line owner tag for the downstream line consumer.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_LINES, 4, maximum lines written per grant before forced rotation (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clr  in  1  synchronous soft clear, same effect as rst; driven with the buffer's clr
- req_valid  in  N  per-requester beat valid
- req_data  in  N*64  per-requester beat; requester i occupies bits [i*64+63:i*64]
- req_last  in  N  beat is the last of its message
- req_ready  out  N  beat accepted this cycle (valid & ready)
- buf_data  out  64  beat to buffer write port
- buf_wr_en  out  1  buffer write strobe
- buf_afull  in  1  buffer cannot take another beat; no write is issued while high
- grant_id  out  $clog2(N)  currently granted requester
- busy  out  1  high in STREAM or PAD
- line_done  out  1  one-cycle pulse, a 512-bit line has been completed
- line_owner  out  $clog2(N)  requester that owns the completed line
- line_last  out  1  completed line contains the end of a message
- line_pad_cnt  out  3  number of zero beats padded into the completed line

Behaviour:
- Reset / clr:
  - state=IDLE, beat_cnt=0, line_cnt=0, rr_ptr=N-1, grant_id=0.
  - All outputs 0: req_ready, buf_wr_en, busy, line_done, line_owner, line_last, line_pad_cnt.
  - Takes effect from any state; a partial line is abandoned. The buffer is cleared by the same clr, so it stays aligned.
- States: IDLE, STREAM, PAD.
- IDLE:
  - If any req_valid is high, grant the first valid requester searching (rr_ptr+1) mod N upward, wrapping.
  - Register grant_id and rr_ptr := grant; next state STREAM.
  - No write in IDLE, so there is 1 cycle from request to first possible acceptance.
- STREAM:
  - req_ready[grant_id] = !buf_afull, combinational. All other req_ready bits are 0.
  - Accept = req_valid[g] & req_ready[g]. On accept: buf_wr_en=1, buf_data=req_data[g], beat_cnt++ (3-bit wrap).
  - Accept with req_last at beat_cnt==7: line complete, line_last=1, pad=0, go IDLE.
  - Accept with req_last at beat_cnt<7: go PAD. pad_remaining = 7-beat_cnt, recorded for line_pad_cnt.
  - Accept without last at beat_cnt==7: line complete, line_cnt++.
    - If line_cnt reaches MAX_LINES, go IDLE (forced rotation, line_last=0).
    - Otherwise stay in STREAM; grant is kept.
  - If req_valid is low, wait in STREAM. Grant is never released mid-line.
- PAD:
  - Each cycle with !buf_afull: buf_wr_en=1, buf_data=0, beat_cnt++.
  - On the write at beat_cnt==7: line complete, go IDLE.
  - req_ready is all 0 in PAD.
- Line completion:
  - line_done pulses in the cycle after the 8th write of a line (registered).
  - line_owner, line_last and line_pad_cnt are valid with the pulse and hold their value until the next pulse.
- line_cnt resets to 0 on every entry to IDLE.
- buf_afull:
  - Sampled combinationally.
  - A beat presented while buf_afull=1 is neither written nor acknowledged.
  - buf_afull has no effect on the state of an in-progress line.
- busy = (state != IDLE).
- Simultaneous events:
  - rst/clr has priority over everything.
  - In IDLE, requests from the previous owner are served only after the other valid requesters in round-robin order.

Test Plan:
- Req0 sends 8 beats 0x0..0x7, last on beat 7 → 8 writes in order. line_done 1 cycle after the 8th write with owner=0, last=1, pad_cnt=0. Back to IDLE.
- Req2 sends 3 beats, last on beat 3 → 3 data writes then 5 zero writes. line_done with owner=2, last=1, pad_cnt=5.
- Req0 and req1 both continuously valid, 1-line messages → lines alternate owners 0,1,0,1. Each grant preceded by 1 IDLE cycle.
- buf_afull held high for 4 cycles at beat 3 → no writes and req_ready=0 during those cycles. Beats resume unchanged with no loss or duplication, and still total 8 per line.
- MAX_LINES=2, req1 streams 24 beats without last while req3 is valid → 2 lines owned by 1 with last=0, then 1 line owned by 3, then req1 resumes.
- clr asserted at beat 5 of a line → next cycle state=IDLE, all outputs 0, no line_done. Next grant goes to requester 0 first.
